// File: rtl/brid_pkg.sv
// Shared types and helpers for the branch-ID manager.
package brid_pkg;

    localparam int unsigned BridWidth      = 2;
    localparam int unsigned NumCheckpoints = 2 ** BridWidth;

    typedef logic [BridWidth-1:0] brid_t;
    typedef logic [BridWidth:0]   brid_cnt_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } brid_state_e;

    // Distance of b from the ring head, modulo the ring size.
    function automatic brid_t brid_age(input brid_t b, input brid_t head);
        return brid_t'(b - head);
    endfunction

endpackage

// File: rtl/brid_manager_if.sv
// Decode/branch-unit handshake and allocator checkpoint signals of the BRID manager.
interface brid_manager_if;
    import brid_pkg::*;

    logic  branch_valid_i;
    logic  branch_ready_o;
    brid_t branch_brid_o;
    logic  resolve_valid_i;
    brid_t resolve_brid_i;
    logic  resolve_mispredict_i;
    logic  alloc_new_checkpoint_o;
    brid_t alloc_brid_o;
    logic  missprediction_o;
    brid_t missprediction_brid_o;

    modport master (
        output branch_valid_i, resolve_valid_i, resolve_brid_i, resolve_mispredict_i,
        input  branch_ready_o, branch_brid_o, alloc_new_checkpoint_o, alloc_brid_o,
               missprediction_o, missprediction_brid_o
    );

    modport slave (
        input  branch_valid_i, resolve_valid_i, resolve_brid_i, resolve_mispredict_i,
        output branch_ready_o, branch_brid_o, alloc_new_checkpoint_o, alloc_brid_o,
               missprediction_o, missprediction_brid_o
    );

endinterface

// File: rtl/brid_manager.sv
// Branch-ID ring: in-order allocate/retire, out-of-order resolve, mispredict rollback.
// Optional statistics counters are enabled by defining BRID_MANAGER_STATS_EN.
module brid_manager
    import brid_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    brid_manager_if.slave  bus,
    output logic           full_o,
    output logic           empty_o,
    output brid_cnt_t      count_o
`ifdef BRID_MANAGER_STATS_EN
    ,
    output logic [15:0]    mispredict_count_o,
    output logic [15:0]    stall_count_o
`endif
);

    brid_state_e               state_q, state_d;
    brid_t                     head_q, head_d;
    brid_t                     tail_q, tail_d;
    brid_cnt_t                 count_q, count_d;
    logic [NumCheckpoints-1:0] valid_q, valid_d;
    logic [NumCheckpoints-1:0] resolved_q, resolved_d;
    logic                      missp_q, missp_d;
    brid_t                     missp_brid_q, missp_brid_d;

    logic ready_c;
    logic fire_c;
    logic resolve_hit_c;
    logic mispredict_c;
    logic retire_c;

    assign full_o  = (count_q == brid_cnt_t'(NumCheckpoints));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign ready_c       = !full_o && (state_q == RUN) && !flush_i
                           && !(bus.resolve_valid_i && bus.resolve_mispredict_i);
    assign fire_c        = bus.branch_valid_i && ready_c;
    assign resolve_hit_c = bus.resolve_valid_i && valid_q[bus.resolve_brid_i];
    assign mispredict_c  = !flush_i && resolve_hit_c && bus.resolve_mispredict_i;
    assign retire_c      = valid_q[head_q] && resolved_q[head_q];

    assign bus.branch_ready_o         = ready_c;
    assign bus.branch_brid_o          = tail_q;
    assign bus.alloc_new_checkpoint_o = fire_c;
    assign bus.alloc_brid_o           = tail_q;
    assign bus.missprediction_o       = missp_q;
    assign bus.missprediction_brid_o  = missp_brid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            resolved_q   <= '0;
            missp_q      <= 1'b0;
            missp_brid_q <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            resolved_q   <= resolved_d;
            missp_q      <= missp_d;
            missp_brid_q <= missp_brid_d;
        end
    end

    // Ring update: flush > mispredict rollback > normal resolve/retire/grant.
    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        valid_d      = valid_q;
        resolved_d   = resolved_q;
        missp_d      = 1'b0;
        missp_brid_d = missp_brid_q;

        if (flush_i) begin
            valid_d    = '0;
            resolved_d = '0;
            head_d     = tail_q;
            count_d    = '0;
            state_d    = RUN;
        end else if (mispredict_c) begin
            // A resolved head may still retire unless it is the mispredicted branch itself.
            if (retire_c && (bus.resolve_brid_i != head_q)) begin
                valid_d[head_q]    = 1'b0;
                resolved_d[head_q] = 1'b0;
                head_d             = head_q + 1'b1;
            end
            for (int unsigned i = 0; i < NumCheckpoints; i++) begin
                if (brid_age(brid_t'(i), head_q) >= brid_age(bus.resolve_brid_i, head_q)) begin
                    valid_d[brid_t'(i)]    = 1'b0;
                    resolved_d[brid_t'(i)] = 1'b0;
                end
            end
            tail_d       = bus.resolve_brid_i;
            count_d      = brid_cnt_t'(brid_age(bus.resolve_brid_i, head_d));
            missp_d      = 1'b1;
            missp_brid_d = bus.resolve_brid_i;
            state_d      = RECOVER;
        end else begin
            if (resolve_hit_c) begin
                resolved_d[bus.resolve_brid_i] = 1'b1;
            end
            if (retire_c) begin
                valid_d[head_q]    = 1'b0;
                resolved_d[head_q] = 1'b0;
                head_d             = head_q + 1'b1;
            end
            if (fire_c) begin
                valid_d[tail_q]    = 1'b1;
                resolved_d[tail_q] = 1'b0;
                tail_d             = tail_q + 1'b1;
            end
            count_d = count_q + brid_cnt_t'(fire_c) - brid_cnt_t'(retire_c);
            state_d = RUN;
        end
    end

`ifdef BRID_MANAGER_STATS_EN
    logic [15:0] mispredict_cnt_q;
    logic [15:0] stall_cnt_q;

    // Saturating event counters; flush leaves them intact.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mispredict_cnt_q <= '0;
            stall_cnt_q      <= '0;
        end else begin
            if (mispredict_c && (mispredict_cnt_q != 16'hFFFF)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
            end
            if (bus.branch_valid_i && !ready_c && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign mispredict_count_o = mispredict_cnt_q;
    assign stall_count_o      = stall_cnt_q;
`endif

endmodule

// File: tb/tb_brid_manager.sv
// Directed self-checking bench for brid_manager (BridWidth = 2).
module tb_brid_manager;
    import brid_pkg::*;

    logic      clk_i;
    logic      rst_ni;
    logic      flush_i;
    logic      full_o;
    logic      empty_o;
    brid_cnt_t count_o;
`ifdef BRID_MANAGER_STATS_EN
    logic [15:0] mispredict_count_o;
    logic [15:0] stall_count_o;
`endif

    int unsigned n_vec;
    int unsigned n_err;

    brid_manager_if bus ();

    brid_manager dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (bus),
        .full_o  (full_o),
        .empty_o (empty_o),
        .count_o (count_o)
`ifdef BRID_MANAGER_STATS_EN
        ,
        .mispredict_count_o (mispredict_count_o),
        .stall_count_o      (stall_count_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        flush_i                  = 1'b0;
        bus.branch_valid_i       = 1'b0;
        bus.resolve_valid_i      = 1'b0;
        bus.resolve_brid_i       = '0;
        bus.resolve_mispredict_i = 1'b0;
    endtask

    // Advance one clock; inputs may be changed right after return.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        #3;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic resolve(input int unsigned b, input logic mis);
        bus.resolve_valid_i      = 1'b1;
        bus.resolve_brid_i       = brid_t'(b);
        bus.resolve_mispredict_i = mis;
    endtask

    task automatic fill(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            bus.branch_valid_i = 1'b1;
            #1;
            check("fill_brid", 32'(bus.branch_brid_o), k);
            tick();
        end
        idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        rst_ni = 1'b0;
        #12;

        // Test 1: reset state and four consecutive grants
        check("rst_count", 32'(count_o), 0);
        check("rst_empty", 32'(empty_o), 1);
        check("rst_full", 32'(full_o), 0);
        check("rst_ready", 32'(bus.branch_ready_o), 1);
        check("rst_missp", 32'(bus.missprediction_o), 0);
        check("rst_missp_brid", 32'(bus.missprediction_brid_o), 0);
        do_reset();
        for (int unsigned k = 0; k < 4; k++) begin
            bus.branch_valid_i = 1'b1;
            #1;
            check("t1_ready", 32'(bus.branch_ready_o), 1);
            check("t1_brid", 32'(bus.branch_brid_o), k);
            check("t1_newckpt", 32'(bus.alloc_new_checkpoint_o), 1);
            check("t1_alloc_brid", 32'(bus.alloc_brid_o), k);
            tick();
        end
        #1;
        check("t1_full", 32'(full_o), 1);
        check("t1_count", 32'(count_o), 4);
        check("t1_ready5", 32'(bus.branch_ready_o), 0);
        check("t1_newckpt5", 32'(bus.alloc_new_checkpoint_o), 0);
        idle();

        // Test 2: out-of-order resolve, in-order retire
        do_reset();
        fill(4);
        resolve(2, 1'b0);
        tick();
        resolve(0, 1'b0);
        tick();
        idle();
        check("t2_count_pre", 32'(count_o), 4);
        tick();
        check("t2_count_ret0", 32'(count_o), 3);
        tick();
        check("t2_count_stall", 32'(count_o), 3);
        resolve(1, 1'b0);
        tick();
        idle();
        tick();
        check("t2_count_ret1", 32'(count_o), 2);
        tick();
        check("t2_count_ret2", 32'(count_o), 1);
        tick();
        check("t2_count_hold", 32'(count_o), 1);

        // Test 3: mispredict rollback
        do_reset();
        fill(4);
        resolve(1, 1'b1);
        bus.branch_valid_i = 1'b1;
        #1;
        check("t3_ready_n", 32'(bus.branch_ready_o), 0);
        check("t3_newckpt_n", 32'(bus.alloc_new_checkpoint_o), 0);
        tick();
        bus.resolve_valid_i      = 1'b0;
        bus.resolve_mispredict_i = 1'b0;
        #1;
        check("t3_missp", 32'(bus.missprediction_o), 1);
        check("t3_missp_brid", 32'(bus.missprediction_brid_o), 1);
        check("t3_count", 32'(count_o), 1);
        check("t3_ready_n1", 32'(bus.branch_ready_o), 0);
        tick();
        #1;
        check("t3_missp_clr", 32'(bus.missprediction_o), 0);
        check("t3_ready_run", 32'(bus.branch_ready_o), 1);
        check("t3_regrant", 32'(bus.branch_brid_o), 1);
        tick();
        idle();
        check("t3_count_after", 32'(count_o), 2);

        // Test 4: mispredict on a BRID not in flight is ignored
        do_reset();
        fill(2);
        resolve(3, 1'b1);
        tick();
        idle();
        #1;
        check("t4_missp", 32'(bus.missprediction_o), 0);
        check("t4_count", 32'(count_o), 2);
        check("t4_ready", 32'(bus.branch_ready_o), 1);
        check("t4_tail", 32'(bus.branch_brid_o), 2);

        // Test 5: flush beats a same-cycle mispredict, tail preserved
        do_reset();
        fill(3);
        flush_i = 1'b1;
        resolve(1, 1'b1);
        tick();
        idle();
        #1;
        check("t5_count", 32'(count_o), 0);
        check("t5_empty", 32'(empty_o), 1);
        check("t5_missp", 32'(bus.missprediction_o), 0);
        bus.branch_valid_i = 1'b1;
        #1;
        check("t5_brid", 32'(bus.branch_brid_o), 3);
        tick();
        idle();
        check("t5_count1", 32'(count_o), 1);

        // Test 6: asynchronous reset during recovery
        do_reset();
        fill(4);
        resolve(2, 1'b1);
        tick();
        idle();
        #1;
        check("t6_missp_pre", 32'(bus.missprediction_o), 1);
        rst_ni = 1'b0;
        #1;
        check("t6_missp", 32'(bus.missprediction_o), 0);
        check("t6_missp_brid", 32'(bus.missprediction_brid_o), 0);
        check("t6_count", 32'(count_o), 0);
        check("t6_empty", 32'(empty_o), 1);
        check("t6_full", 32'(full_o), 0);
        check("t6_ready", 32'(bus.branch_ready_o), 1);
        #3;
        rst_ni = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
